// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Round-robin arbiter that funnels NPORT memory requesters onto a single
//   32-bit RAM port. Handles byte/half/word lanes for loads and stores,
//   sign/zero extension of loads, and flags misaligned or illegal-size
//   requests without touching the RAM.
//
// Optional build macro:
//   MEM_REQ_TIMEOUT_EN - when defined, an access that sees busy_o high for
//                        TIMEOUT_CYC consecutive cycles is abandoned and
//                        answered with req_err = 1, req_rdata = 0.
//
// Ports:
//   CLK, nRST      clock (rising edge), asynchronous active-low reset
//   req_valid      per-port request pending, held until req_ready
//   req_wen        per-port 1 = store, 0 = load
//   req_size       per-port 2-bit size (00 byte, 01 half, 10 word, 11 illegal)
//   req_unsigned   per-port zero-extend loads
//   req_addr       per-port byte address, port i at [i*ADDR_W +: ADDR_W]
//   req_wdata      per-port right-justified store data, port i at [i*32 +: 32]
//   req_ready      one-cycle completion pulse to the granted port
//   req_rdata      load result, held between responses
//   req_err        error flag, valid with req_ready
//   Ren, Wen       RAM read / write enables (only in ACCESS)
//   ramaddr        word-aligned RAM address
//   ramstore       lane-replicated store data
//   ram_be         RAM byte enables
//   ramload        RAM read data
//   busy_o         RAM busy; access completes on first edge with busy_o = 0
//
// State  | Meaning
// IDLE   | pick next requester round-robin, latch its request
// ACCESS | drive RAM from latched request, wait out busy_o
// RESP   | pulse req_ready to the granted port, advance rr pointer

module mem_req_arbiter #(
    parameter int NPORT       = 2,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NPORT-1:0]        req_valid,
    input  logic [NPORT-1:0]        req_wen,
    input  logic [2*NPORT-1:0]      req_size,
    input  logic [NPORT-1:0]        req_unsigned,
    input  logic [NPORT*ADDR_W-1:0] req_addr,
    input  logic [32*NPORT-1:0]     req_wdata,
    output logic [NPORT-1:0]        req_ready,
    output logic [31:0]             req_rdata,
    output logic                    req_err,
    output logic                    Ren,
    output logic                    Wen,
    output logic [ADDR_W-1:0]       ramaddr,
    output logic [31:0]             ramstore,
    output logic [3:0]              ram_be,
    input  logic [31:0]             ramload,
    input  logic                    busy_o
);

    localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t state, state_nxt;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  gnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              wen_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TMO_W-1:0] tmo_cnt;
`endif

    // ------------------------------------------------------------------
    // Round-robin grant: first valid port at or after rr_ptr, wrapping.
    // ------------------------------------------------------------------
    logic             gnt_found;
    logic [PTR_W-1:0] gnt_sel;
    int               cand;
    logic [PTR_W-1:0] cand_idx;

    always_comb begin
        gnt_found = 1'b0;
        gnt_sel   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NPORT; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NPORT) begin
                cand = cand - NPORT;
            end
            cand_idx = PTR_W'(cand);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_sel   = cand_idx;
            end
        end
    end

    // Request fields of the port being granted this cycle.
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_size;
    logic              sel_wen;
    logic              sel_uns;
    logic [31:0]       sel_wdata;
    logic              sel_err;

    always_comb begin
        sel_addr  = '0;
        sel_size  = '0;
        sel_wen   = 1'b0;
        sel_uns   = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (gnt_sel == PTR_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_size  = req_size[2*i +: 2];
                sel_wen   = req_wen[i];
                sel_uns   = req_unsigned[i];
                sel_wdata = req_wdata[i*32 +: 32];
            end
        end
        sel_err = (sel_size == SZ_ILL)
                | ((sel_size == SZ_HALF) & sel_addr[0])
                | ((sel_size == SZ_WORD) & (sel_addr[1:0] != 2'b00));
    end

    // ------------------------------------------------------------------
    // Lane steering from the latched request.
    // ------------------------------------------------------------------
    logic [3:0]  be_lane;
    logic [31:0] store_lane;
    logic [31:0] load_sh;
    logic [31:0] load_ext;

    always_comb begin
        be_lane    = 4'b1111;
        store_lane = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                be_lane    = 4'b0001 << addr_q[1:0];
                store_lane = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                be_lane    = 4'b0011 << addr_q[1:0];
                store_lane = {2{wdata_q[15:0]}};
            end
            default: begin
                be_lane    = 4'b1111;
                store_lane = wdata_q;
            end
        endcase
    end

    always_comb begin
        load_sh  = ramload >> {addr_q[1:0], 3'b000};
        load_ext = load_sh;
        case (size_q)
            SZ_BYTE: load_ext = uns_q ? {24'h0, load_sh[7:0]}
                                      : {{24{load_sh[7]}}, load_sh[7:0]};
            SZ_HALF: load_ext = uns_q ? {16'h0, load_sh[15:0]}
                                      : {{16{load_sh[15]}}, load_sh[15:0]};
            default: load_ext = load_sh;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        req_err   = 1'b0;
        Ren       = 1'b0;
        Wen       = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        ram_be    = '0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    state_nxt = sel_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                Ren      = ~wen_q;
                Wen      = wen_q;
                ramaddr  = {addr_q[ADDR_W-1:2], 2'b00};
                ramstore = store_lane;
                ram_be   = be_lane;
                if (!busy_o) begin
                    state_nxt = RESP;
                end
`ifdef MEM_REQ_TIMEOUT_EN
                else if (tmo_cnt == '0) begin
                    state_nxt = RESP;
                end
`endif
            end
            RESP: begin
                req_ready[gnt_q] = 1'b1;
                req_err          = err_q;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latches, response data and rr pointer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr  <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        gnt_q   <= gnt_sel;
                        addr_q  <= sel_addr;
                        size_q  <= sel_size;
                        wen_q   <= sel_wen;
                        uns_q   <= sel_uns;
                        wdata_q <= sel_wdata;
                        err_q   <= sel_err;
                        // Error responses skip ACCESS, so their data is set here.
                        if (sel_err) begin
                            rdata_q <= '0;
                        end
`ifdef MEM_REQ_TIMEOUT_EN
                        tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
`endif
                    end
                end
                ACCESS: begin
                    if (!busy_o) begin
                        rdata_q <= wen_q ? 32'h0 : load_ext;
                    end
`ifdef MEM_REQ_TIMEOUT_EN
                    else if (tmo_cnt == '0) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (gnt_q == PTR_W'(NPORT - 1)) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= gnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_rdata = rdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter (NPORT = 2, ADDR_W = 32).
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.

module tb_mem_req_arbiter;

    localparam int NPORT  = 2;
    localparam int ADDR_W = 32;

    logic                    CLK = 1'b0;
    logic                    nRST;
    logic [NPORT-1:0]        req_valid;
    logic [NPORT-1:0]        req_wen;
    logic [2*NPORT-1:0]      req_size;
    logic [NPORT-1:0]        req_unsigned;
    logic [NPORT*ADDR_W-1:0] req_addr;
    logic [32*NPORT-1:0]     req_wdata;
    logic [NPORT-1:0]        req_ready;
    logic [31:0]             req_rdata;
    logic                    req_err;
    logic                    Ren;
    logic                    Wen;
    logic [ADDR_W-1:0]       ramaddr;
    logic [31:0]             ramstore;
    logic [3:0]              ram_be;
    logic [31:0]             ramload;
    logic                    busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    mem_req_arbiter #(
        .NPORT      (NPORT),
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(8)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .req_valid   (req_valid),
        .req_wen     (req_wen),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .req_rdata   (req_rdata),
        .req_err     (req_err),
        .Ren         (Ren),
        .Wen         (Wen),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ram_be      (ram_be),
        .ramload     (ramload),
        .busy_o      (busy_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_port(input int p, input logic wen, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        req_wen[p]                     = wen;
        req_size[2*p +: 2]             = size;
        req_unsigned[p]                = uns;
        req_addr[p*ADDR_W +: ADDR_W]   = addr;
        req_wdata[p*32 +: 32]          = wdata;
    endtask

    // Single-port load/store through IDLE -> ACCESS -> RESP with busy_o low.
    task automatic one_txn(input string tag, input int p, input logic wen, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] load, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_store,
                           input logic [31:0] exp_rdata);
        set_port(p, wen, size, uns, addr, wdata);
        ramload   = load;
        busy_o    = 1'b0;
        req_valid = 2'b00;
        req_valid[p] = 1'b1;
        tick;
        check({tag, "_ren"},   32'(Ren), 32'(!wen));
        check({tag, "_wen"},   32'(Wen), 32'(wen));
        check({tag, "_addr"},  ramaddr, exp_addr);
        check({tag, "_be"},    32'(ram_be), 32'(exp_be));
        if (wen) check({tag, "_store"}, ramstore, exp_store);
        check({tag, "_rdy0"},  32'(req_ready), 32'h0);
        tick;
        check({tag, "_rdy"},   32'(req_ready), 32'(2'b01 << p));
        check({tag, "_rdata"}, req_rdata, exp_rdata);
        check({tag, "_err"},   32'(req_err), 32'h0);
        check({tag, "_ren_resp"}, 32'(Ren | Wen), 32'h0);
        req_valid = 2'b00;
        tick;
        check({tag, "_rdy_idle"}, 32'(req_ready), 32'h0);
    endtask

    initial begin
        nRST         = 1'b0;
        req_valid    = '0;
        req_wen      = '0;
        req_size     = '0;
        req_unsigned = '0;
        req_addr     = '0;
        req_wdata    = '0;
        ramload      = '0;
        busy_o       = 1'b0;
        #12;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_ren",   32'(Ren), 32'h0);
        check("rst_wen",   32'(Wen), 32'h0);
        check("rst_be",    32'(ram_be), 32'h0);
        check("rst_rdata", req_rdata, 32'h0);
        check("rst_err",   32'(req_err), 32'h0);
        nRST = 1'b1;
        tick;

        // Sub-word loads and stores
        one_txn("lb",  1, 1'b0, 2'b00, 1'b0, 32'h5678_5679, 32'h0, 32'h4321_8034,
                32'h5678_5678, 4'b0010, 32'h0, 32'hFFFF_FF80);
        check("rdata_hold", req_rdata, 32'hFFFF_FF80);
        one_txn("lbu", 1, 1'b0, 2'b00, 1'b1, 32'h5678_5679, 32'h0, 32'h4321_8034,
                32'h5678_5678, 4'b0010, 32'h0, 32'h0000_0080);
        one_txn("sh",  1, 1'b1, 2'b01, 1'b0, 32'hABCD_ABCE, 32'h3333_1234, 32'h0,
                32'hABCD_ABCC, 4'b1100, 32'h1234_1234, 32'h0);
        one_txn("lh",  0, 1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0, 32'h8001_1234,
                32'h0000_1000, 4'b1100, 32'h0, 32'hFFFF_8001);
        one_txn("lhu", 0, 1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0, 32'h8001_1234,
                32'h0000_1000, 4'b1100, 32'h0, 32'h0000_8001);
        one_txn("sb",  0, 1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h0000_00AB, 32'h0,
                32'h0000_0000, 4'b1000, 32'hABAB_ABAB, 32'h0);

        // Round robin: rr pointer is 1 after the last port-0 grant, so port 1 goes first.
        set_port(0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        set_port(1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
        ramload   = 32'hDEAD_BEEF;
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            logic [31:0] exp_a;
            logic [1:0]  exp_r;
            exp_a = (n % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100;
            exp_r = (n % 2 == 0) ? 2'b10 : 2'b01;
            tick;
            check("rr_addr", ramaddr, exp_a);
            check("rr_rdy0", 32'(req_ready), 32'h0);
            tick;
            check("rr_rdy",  32'(req_ready), 32'(exp_r));
            check("rr_data", req_rdata, 32'hDEAD_BEEF);
            tick;
        end
        req_valid = 2'b00;

        // Wait states: busy_o high for 4 ACCESS cycles, Ren high for 5.
        set_port(0, 1'b0, 2'b10, 1'b0, 32'h1111_1110, 32'h0);
        ramload   = 32'h2222_2222;
        busy_o    = 1'b1;
        req_valid = 2'b01;
        tick;
        for (int n = 0; n < 4; n++) begin
            check("ws_ren", 32'(Ren), 32'h1);
            check("ws_rdy", 32'(req_ready), 32'h0);
            tick;
        end
        busy_o = 1'b0;
        check("ws_ren5", 32'(Ren), 32'h1);
        tick;
        check("ws_rdy_resp", 32'(req_ready), 32'h1);
        check("ws_rdata",    req_rdata, 32'h2222_2222);
        req_valid = 2'b00;
        tick;

        // Reset mid-ACCESS (rr = 1 -> port 1 granted first)
        set_port(1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
        busy_o    = 1'b1;
        req_valid = 2'b10;
        tick;
        check("mr_ren_pre", 32'(Ren), 32'h1);
        #2 nRST = 1'b0;
        #1;
        check("mr_ren", 32'(Ren), 32'h0);
        check("mr_wen", 32'(Wen), 32'h0);
        check("mr_rdy", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        busy_o    = 1'b0;
        #2 nRST = 1'b1;
        tick;
        check("mr_idle_ren", 32'(Ren), 32'h0);
        check("mr_idle_rdy", 32'(req_ready), 32'h0);
        // rr pointer back at 0 after reset: port 0 wins.
        set_port(0, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
        req_valid = 2'b11;
        tick;
        check("mr_rr_addr", ramaddr, 32'h0000_0300);
        tick;
        check("mr_rr_rdy", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        tick;

        // Misaligned word and illegal size: response on cycle 2, no RAM access.
        set_port(0, 1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0);
        req_valid = 2'b01;
        check("mis_ren_idle", 32'(Ren | Wen), 32'h0);
        tick;
        check("mis_rdy", 32'(req_ready), 32'h1);
        check("mis_err", 32'(req_err), 32'h1);
        check("mis_ram", 32'(Ren | Wen), 32'h0);
        req_valid = 2'b00;
        tick;
        check("mis_err_idle", 32'(req_err), 32'h0);

        set_port(1, 1'b1, 2'b11, 1'b0, 32'h0000_0040, 32'h5);
        req_valid = 2'b10;
        tick;
        check("ill_rdy", 32'(req_ready), 32'h2);
        check("ill_err", 32'(req_err), 32'h1);
        check("ill_ram", 32'(Ren | Wen), 32'h0);
        req_valid = 2'b00;
        tick;

        set_port(0, 1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0);
        req_valid = 2'b01;
        tick;
        check("mish_err", 32'(req_err), 32'h1);
        check("mish_rdy", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        tick;

`ifdef MEM_REQ_TIMEOUT_EN
        // Timeout after 8 busy ACCESS cycles.
        set_port(0, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0);
        ramload   = 32'h5555_5555;
        busy_o    = 1'b1;
        req_valid = 2'b01;
        tick;
        for (int n = 0; n < 8; n++) begin
            check("to_ren", 32'(Ren), 32'h1);
            tick;
        end
        check("to_ren_drop", 32'(Ren), 32'h0);
        check("to_rdy",      32'(req_ready), 32'h1);
        check("to_err",      32'(req_err), 32'h1);
        check("to_rdata",    req_rdata, 32'h0);
        req_valid = 2'b00;
        busy_o    = 1'b0;
        tick;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
